// File: rtl/fme_satd_feed_4x4.sv
// Streams 4x4 rows of current and subpel pels from two row memories
// into a SATD engine, one row per cycle, for a run of 4x4 blocks.
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif

module fme_satd_feed_4x4 (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic [3:0]                blk_idx_i,
  input  logic [4:0]                num_blk_i,
  output logic                      cmb_rd_en_o,
  output logic [3:0]                cmb_rd_addr_o,
  input  logic [16*`BIT_DEPTH-1:0]  cmb_rd_data_i,
  output logic                      sp_rd_en_o,
  output logic [3:0]                sp_rd_addr_o,
  input  logic [16*`BIT_DEPTH-1:0]  sp_rd_data_i,
  output logic [`BIT_DEPTH-1:0]     cmb_p0_o,
  output logic [`BIT_DEPTH-1:0]     cmb_p1_o,
  output logic [`BIT_DEPTH-1:0]     cmb_p2_o,
  output logic [`BIT_DEPTH-1:0]     cmb_p3_o,
  output logic [`BIT_DEPTH-1:0]     sp0_o,
  output logic [`BIT_DEPTH-1:0]     sp1_o,
  output logic [`BIT_DEPTH-1:0]     sp2_o,
  output logic [`BIT_DEPTH-1:0]     sp3_o,
  output logic                      valid_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int PW = `BIT_DEPTH;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [3:0] blk_q;
  logic [1:0] row_q;
  logic [5:0] rem_q;
  logic       drn_q;

  logic       rd_en_q;
  logic [3:0] rd_addr_q;

  logic       dv_q;
  logic [1:0] dcol_q;

  logic          valid_q;
  logic          done_q;
  logic [PW-1:0] cmb_q [4];
  logic [PW-1:0] sp_q  [4];
  logic [PW-1:0] cmb_sel [4];
  logic [PW-1:0] sp_sel  [4];

  logic       last_rd;
  logic [3:0] blk_nx;
  logic [1:0] row_nx;
  logic [4:0] num_eff;
  logic [5:0] rem_init;

  assign last_rd = (rem_q == 6'd0);
  assign row_nx  = row_q + 2'd1;
  assign blk_nx  = (row_q == 2'd3) ? blk_q + 4'd1 : blk_q;

  // zero encodes a full macroblock of 16 blocks
  assign num_eff  = (num_blk_i == 5'd0) ? 5'd16 : num_blk_i;
  assign rem_init = 6'({num_eff, 2'b00} - 7'd1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = READ;
      READ:    if (last_rd) state_d = DRAIN;
      DRAIN:   if (drn_q)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      blk_q     <= '0;
      row_q     <= '0;
      rem_q     <= '0;
      drn_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == DRAIN) && !drn_q;
      unique case (state_q)
        IDLE: begin
          drn_q <= 1'b0;
          if (start_i) begin
            blk_q     <= blk_idx_i;
            row_q     <= 2'd0;
            rem_q     <= rem_init;
            rd_en_q   <= 1'b1;
            rd_addr_q <= {blk_idx_i[3:2], 2'b00};
          end
        end
        READ: begin
          if (last_rd) begin
            rd_en_q <= 1'b0;
          end else begin
            row_q     <= row_nx;
            blk_q     <= blk_nx;
            rem_q     <= rem_q - 6'd1;
            rd_addr_q <= {blk_nx[3:2], row_nx};
          end
        end
        DRAIN: drn_q <= ~drn_q;
        default: drn_q <= 1'b0;
      endcase
    end
  end

  // remember which block column each in-flight read belongs to
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dv_q   <= 1'b0;
      dcol_q <= '0;
    end else begin
      dv_q <= rd_en_q;
      if (rd_en_q) dcol_q <= blk_q[1:0];
    end
  end

  always_comb begin
    logic [3:0] col;
    for (int k = 0; k < 4; k++) begin
      col = {dcol_q, k[1:0]};
      cmb_sel[k] = cmb_rd_data_i[int'(col)*PW +: PW];
      sp_sel[k]  = sp_rd_data_i[int'(col)*PW +: PW];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        cmb_q[k] <= '0;
        sp_q[k]  <= '0;
      end
    end else begin
      valid_q <= dv_q;
      if (dv_q) begin
        for (int k = 0; k < 4; k++) begin
          cmb_q[k] <= cmb_sel[k];
          sp_q[k]  <= sp_sel[k];
        end
      end
    end
  end

  assign cmb_rd_en_o   = rd_en_q;
  assign sp_rd_en_o    = rd_en_q;
  assign cmb_rd_addr_o = rd_addr_q;
  assign sp_rd_addr_o  = rd_addr_q;

  assign cmb_p0_o = cmb_q[0];
  assign cmb_p1_o = cmb_q[1];
  assign cmb_p2_o = cmb_q[2];
  assign cmb_p3_o = cmb_q[3];
  assign sp0_o    = sp_q[0];
  assign sp1_o    = sp_q[1];
  assign sp2_o    = sp_q[2];
  assign sp3_o    = sp_q[3];

  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_fme_satd_feed_4x4.sv
// Directed bench for fme_satd_feed_4x4 with behavioural row memories.
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif

module tb_fme_satd_feed_4x4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   blk_idx = '0;
  logic [4:0]   num_blk = '0;
  logic         cmb_rd_en;
  logic [3:0]   cmb_rd_addr;
  logic [127:0] cmb_rd_data = '0;
  logic         sp_rd_en;
  logic [3:0]   sp_rd_addr;
  logic [127:0] sp_rd_data = '0;
  logic [7:0]   cmb_p0, cmb_p1, cmb_p2, cmb_p3;
  logic [7:0]   sp0, sp1, sp2, sp3;
  logic         valid;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  fme_satd_feed_4x4 dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .blk_idx_i     (blk_idx),
    .num_blk_i     (num_blk),
    .cmb_rd_en_o   (cmb_rd_en),
    .cmb_rd_addr_o (cmb_rd_addr),
    .cmb_rd_data_i (cmb_rd_data),
    .sp_rd_en_o    (sp_rd_en),
    .sp_rd_addr_o  (sp_rd_addr),
    .sp_rd_data_i  (sp_rd_data),
    .cmb_p0_o      (cmb_p0),
    .cmb_p1_o      (cmb_p1),
    .cmb_p2_o      (cmb_p2),
    .cmb_p3_o      (cmb_p3),
    .sp0_o         (sp0),
    .sp1_o         (sp1),
    .sp2_o         (sp2),
    .sp3_o         (sp3),
    .valid_o       (valid),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  // pel at (row, col) is row*16+col; subpel memory XORs with A5
  function automatic logic [7:0] pel(int row, int col, logic [7:0] x);
    return 8'((row * 16 + col) & 255) ^ x;
  endfunction

  function automatic logic [127:0] mk_word(logic [3:0] row, logic [7:0] x);
    logic [127:0] w;
    w = '0;
    for (int c = 0; c < 16; c++) w[c*8 +: 8] = pel(int'(row), c, x);
    return w;
  endfunction

  always @(posedge clk) begin
    if (cmb_rd_en) cmb_rd_data <= mk_word(cmb_rd_addr, 8'h00);
    if (sp_rd_en)  sp_rd_data  <= mk_word(sp_rd_addr, 8'hA5);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_blk(int idx, int i);
    return (idx + i / 4) % 16;
  endfunction

  function automatic int exp_addr(int idx, int i);
    return (exp_blk(idx, i) / 4) * 4 + i % 4;
  endfunction

  task automatic chk_pels(string tag, int idx, int i);
    int row;
    int cb;
    row = exp_addr(idx, i);
    cb  = (exp_blk(idx, i) % 4) * 4;
    chk({tag, "_cmb"}, {cmb_p3, cmb_p2, cmb_p1, cmb_p0},
        {pel(row, cb + 3, 8'h00), pel(row, cb + 2, 8'h00),
         pel(row, cb + 1, 8'h00), pel(row, cb, 8'h00)});
    chk({tag, "_sp"}, {sp3, sp2, sp1, sp0},
        {pel(row, cb + 3, 8'hA5), pel(row, cb + 2, 8'hA5),
         pel(row, cb + 1, 8'hA5), pel(row, cb, 8'hA5)});
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ctl"}, 32'({busy, valid, done, cmb_rd_en, sp_rd_en}), 32'd0);
    chk({tag, "_addr"}, 32'({cmb_rd_addr, sp_rd_addr}), 32'd0);
    chk({tag, "_cmb"}, {cmb_p3, cmb_p2, cmb_p1, cmb_p0}, 32'd0);
    chk({tag, "_sp"}, {sp3, sp2, sp1, sp0}, 32'd0);
  endtask

  // called at a negedge; start is sampled at the next posedge (E0)
  task automatic do_run(input logic [3:0] idx, input logic [4:0] num,
                        input bit inject, input int abort_row);
    int n;
    int total;
    n = (num == 5'd0) ? 16 : int'(num);
    total = 4 * n;
    start = 1'b1;
    blk_idx = idx;
    num_blk = num;
    @(negedge clk);
    start = 1'b0;
    blk_idx = ~idx;
    num_blk = 5'd3;
    for (int cyc = 1; cyc <= total + 4; cyc++) begin
      int j;
      int ai;
      j  = cyc - 3;
      ai = (cyc <= total) ? cyc - 1 : total - 1;
      chk("busy", 32'(busy), 32'(cyc <= total + 2));
      chk("rd_en", 32'({cmb_rd_en, sp_rd_en}),
          (cyc <= total) ? 32'd3 : 32'd0);
      chk("rd_addr", 32'(cmb_rd_addr), 32'(exp_addr(int'(idx), ai)));
      chk("sp_addr", 32'(sp_rd_addr), 32'(exp_addr(int'(idx), ai)));
      chk("valid", 32'(valid), 32'(j >= 0 && j < total));
      chk("done", 32'(done), 32'(j == total - 1));
      if (j >= 0) chk_pels("pels", int'(idx), (j < total) ? j : total - 1);
      if (abort_row >= 0 && j == abort_row) begin
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        chk_zero("midrst_hold");
        rst_n = 1'b1;
        return;
      end
      if (inject && (cyc == 5 || cyc == total + 2)) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    chk_zero("reset_clk");
    rst_n = 1'b1;

    // single block 5: rows 4..7, columns 4..7
    do_run(4'd5, 5'd1, 1'b0, -1);
    chk("hold_p0", 32'(cmb_p0), 32'd116);
    chk("hold_p3", 32'(cmb_p3), 32'd119);
    chk("hold_sp0", 32'(sp0), 32'hD1);
    chk("hold_addr", 32'(cmb_rd_addr), 32'd7);

    // full macroblock encoded as zero
    do_run(4'd0, 5'd0, 1'b0, -1);
    chk("full_p0", 32'(cmb_p0), 32'd252);

    // index wraps 14,15,0,1
    do_run(4'd14, 5'd4, 1'b0, -1);
    chk("wrap_p0", 32'(cmb_p0), 32'd52);
    chk("wrap_addr", 32'(sp_rd_addr), 32'd3);

    // start pulses mid-run and in the done cycle are ignored
    do_run(4'd9, 5'd2, 1'b1, -1);
    do_run(4'd2, 5'd3, 1'b1, -1);

    // reset at row 6 of a 16-block run, then start right after release
    do_run(4'd0, 5'd0, 1'b0, 6);
    do_run(4'd3, 5'd2, 1'b0, -1);
    do_run(4'd15, 5'd16, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
